md_ctrl: RTL and testbench

//   Sequencer for the multiply/divide unit beside the E-stage ALU. Decodes E-stage MDU ops and

---
 rtl/md_ctrl_pkg.sv | 33 +++
 rtl/md_ctrl_if.sv | 27 ++
 rtl/md_calc.sv | 45 ++++
 rtl/md_ctrl.sv | 95 +++++++++
 tb/tb_md_ctrl.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: MDU op encoding, FSM states, op decode helpers.
package md_ctrl_pkg;

  typedef enum logic [3:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MFHI  = 4'd5,
    MDOP_MFLO  = 4'd6,
    MDOP_MTHI  = 4'd7,
    MDOP_MTLO  = 4'd8
  } mdop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_mult(mdop_e op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU);
  endfunction

  function automatic logic is_div(mdop_e op);
    return (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

  function automatic logic is_start(mdop_e op);
    return is_mult(op) || is_div(op);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// E-stage/D-stage connection between the control unit (master) and the MDU sequencer (slave).
interface md_ctrl_if;
  import md_ctrl_pkg::*;

  // Flow control: md_stall = D_is_md & (start | busy). The CU must hold the D-stage MDU op
  // while md_stall is high, so E only sees a new MDU op once busy is low.
  mdop_e       E_mdop;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_mdout;

  modport master (
    output E_mdop, E_rs, E_rt, D_is_md,
    input  busy, md_stall, HI, LO, E_mdout
  );

  modport slave (
    input  E_mdop, E_rs, E_rt, D_is_md,
    output busy, md_stall, HI, LO, E_mdout
  );

endinterface

// File: rtl/md_calc.sv
// Combinational 64-bit {HI,LO} result for mult/multu/div/divu; divide by zero returns the current HI/LO.
module md_calc
  import md_ctrl_pkg::*;
(
  input  mdop_e       mdop,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] abs_rs, abs_rt;
  logic        [31:0] q_mag, r_mag;
  logic        [31:0] q_s, r_s;
  logic        [31:0] q_u, r_u;

  always_comb begin
    prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder follows the dividend.
    abs_rs = rs[31] ? (~rs + 32'd1) : rs;
    abs_rt = rt[31] ? (~rt + 32'd1) : rt;
    q_mag  = (abs_rt == 32'd0) ? 32'd0 : abs_rs / abs_rt;
    r_mag  = (abs_rt == 32'd0) ? 32'd0 : abs_rs % abs_rt;
    q_s    = (rs[31] ^ rt[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = rs[31] ? (~r_mag + 32'd1) : r_mag;

    q_u    = (rt == 32'd0) ? 32'd0 : rs / rt;
    r_u    = (rt == 32'd0) ? 32'd0 : rs % rt;

    result = {hi, lo};
    case (mdop)
      MDOP_MULT:  result = prod_s;
      MDOP_MULTU: result = prod_u;
      MDOP_DIV:   if (rt != 32'd0) result = {r_s, q_s};
      MDOP_DIVU:  if (rt != 32'd0) result = {r_u, q_u};
      default:    result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// MDU sequencer: launches mul/div from E, holds busy for a fixed latency, then commits HI/LO.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_ctrl_if.slave   md,
  output md_state_e  dbg_state
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  md_state_e   state, next_state;
  logic [CW-1:0] cnt;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi, pend_lo;
  logic [63:0] calc_result;
  logic        start;

  assign start = is_start(md.E_mdop);

  md_calc u_calc (
    .mdop   (md.E_mdop),
    .rs     (md.E_rs),
    .rt     (md.E_rt),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (calc_result)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_BUSY;
      ST_BUSY: if (cnt == '0) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state == ST_BUSY);
      case (state)
        ST_IDLE: begin
          if (start) begin
            pend_hi <= calc_result[63:32];
            pend_lo <= calc_result[31:0];
            cnt     <= is_mult(md.E_mdop) ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
          end else if (md.E_mdop == MDOP_MTHI) begin
            hi_q <= md.E_rs;
          end else if (md.E_mdop == MDOP_MTLO) begin
            lo_q <= md.E_rs;
          end
        end
        ST_BUSY: begin
          // Any MDU op reaching E here is a pipeline flush bug and is ignored.
          if (cnt == '0) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    md.E_mdout = 32'd0;
    if (md.E_mdop == MDOP_MFHI) md.E_mdout = hi_q;
    else if (md.E_mdop == MDOP_MFLO) md.E_mdout = lo_q;
  end

  assign md.busy     = busy_q;
  assign md.md_stall = md.D_is_md & (start | busy_q);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: mul/div results and latency, div-by-zero hold, mt*/mf*, stall, reset abort.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  logic      clk;
  logic      reset;
  md_state_e dbg_state;
  int        n_checks;
  int        n_errors;

  md_ctrl_if bus ();

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md        (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // The stall must keep every MDU op out of E while busy.
  always @(negedge clk) begin
    if (!reset && bus.busy && bus.E_mdop != MDOP_NONE)
      check("op_in_e_while_busy", {28'd0, bus.E_mdop}, {28'd0, MDOP_NONE});
  end

  task automatic run_op(input string tag, input mdop_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic d_md, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cycles;
    int stall_cycles;
    @(negedge clk);
    bus.E_mdop  = op;
    bus.E_rs    = rs;
    bus.E_rt    = rt;
    bus.D_is_md = d_md;
    #1;
    check({tag, "_start_stall"}, 32'(bus.md_stall), 32'(d_md));
    @(negedge clk);
    bus.E_mdop = MDOP_NONE;
    check({tag, "_state_busy"}, 32'(dbg_state), 32'(ST_BUSY));
    cycles = 0;
    stall_cycles = 0;
    while (bus.busy && cycles < 64) begin
      cycles++;
      if (bus.md_stall) stall_cycles++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(cycles), 32'(exp_n));
    check({tag, "_stall_cycles"}, 32'(stall_cycles), d_md ? 32'(exp_n) : 32'd0);
    check({tag, "_stall_after"}, 32'(bus.md_stall), 32'd0);
    check({tag, "_hi"}, bus.HI, exp_hi);
    check({tag, "_lo"}, bus.LO, exp_lo);
  endtask

  task automatic move_to(input string tag, input mdop_e op, input logic [31:0] rs,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    bus.E_mdop  = op;
    bus.E_rs    = rs;
    bus.D_is_md = 1'b0;
    #1;
    check({tag, "_stall"}, 32'(bus.md_stall), 32'd0);
    @(negedge clk);
    bus.E_mdop = MDOP_NONE;
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_hi"}, bus.HI, exp_hi);
    check({tag, "_lo"}, bus.LO, exp_lo);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    bus.E_mdop  = MDOP_NONE;
    bus.E_rs    = 32'd0;
    bus.E_rt    = 32'd0;
    bus.D_is_md = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    bus.D_is_md = 1'b1;
    #1;
    check("idle_no_start_stall", 32'(bus.md_stall), 32'd0);
    bus.D_is_md = 1'b0;

    run_op("mult",  MDOP_MULT,  32'hFFFFFFFE, 32'd3, 1'b0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", MDOP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("multu_max", MDOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 32'hFFFFFFFE, 32'h00000001);
    run_op("div",   MDOP_DIV,   32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negdivisor", MDOP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",  MDOP_DIVU,  32'd7, 32'd2, 1'b0, 10, 32'd1, 32'd3);

    move_to("mthi11", MDOP_MTHI, 32'h11, 32'h11, 32'd3);
    move_to("mtlo22", MDOP_MTLO, 32'h22, 32'h11, 32'h22);
    run_op("div0",  MDOP_DIV,   32'd123, 32'd0, 1'b0, 10, 32'h11, 32'h22);
    run_op("divu0", MDOP_DIVU,  32'd123, 32'd0, 1'b0, 10, 32'h11, 32'h22);

    run_op("mult_stall", MDOP_MULT, 32'h12345678, 32'h10, 1'b1, 5, 32'h00000001, 32'h23456780);
    bus.E_mdop = MDOP_MFLO;
    #1;
    check("mflo_out", bus.E_mdout, 32'h23456780);
    bus.E_mdop = MDOP_MFHI;
    #1;
    check("mfhi_out", bus.E_mdout, 32'h00000001);
    bus.E_mdop = MDOP_NONE;
    #1;
    check("none_out", bus.E_mdout, 32'd0);

    move_to("mthi_dead", MDOP_MTHI, 32'hDEADBEEF, 32'hDEADBEEF, 32'h23456780);

    // Abort a divide on its 4th busy cycle.
    @(negedge clk);
    bus.E_mdop = MDOP_DIV;
    bus.E_rs   = 32'd100;
    bus.E_rt   = 32'd7;
    @(negedge clk);
    bus.E_mdop = MDOP_NONE;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (15) @(negedge clk);
    check("abort_no_commit_busy", 32'(bus.busy), 32'd0);
    check("abort_no_commit_hi", bus.HI, 32'd0);
    check("abort_no_commit_lo", bus.LO, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
